load_store_unit: RTL

Initiator-side memory access unit for the CPU datapath. It accepts byte, halfword and word load/store requests from the execute/memory stage and drives the word-only data memory port (`mem_rd`/`mem_wr`, word-indexed by `addr[10:2]` on the memory side). Sub-word stores are performed as read-modify-write sequences. Load data is returned sign- or zero-extended.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 43 ++++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states and
// the natural-alignment check.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } lsu_state_e;

    // Reserved size 2'b11 is always reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            SZ_WORD: mis = (lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane datapath: extracts and extends load data from a memory word, and merges
// right-aligned store data into a read word for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lo_i,
    input  logic        sgn_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    always_comb begin
        shamt   = {lo_i, 3'b000};
        shifted = rdata_i >> shamt;

        load_data_o = rdata_i;
        lane_mask   = '1;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {{24{sgn_i & shifted[7]}}, shifted[7:0]};
                lane_mask   = 32'h0000_00FF;
            end
            SZ_HALF: begin
                load_data_o = {{16{sgn_i & shifted[15]}}, shifted[15:0]};
                lane_mask   = 32'h0000_FFFF;
            end
            default: begin
                load_data_o = rdata_i;
                lane_mask   = '1;
            end
        endcase

        merged_o = (rdata_i & ~(lane_mask << shamt)) | ((wdata_i << shamt) & (lane_mask << shamt));
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: FSM driving a word-only memory port with RMW for sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to report misaligned/reserved requests as errors instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state_q;
    logic [1:0]        size_q;
    logic [1:0]        lo_q;
    logic              sgn_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req_ready_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_rd_q;
    logic              mem_wr_q;

    logic [1:0]        acc_size;
    logic [1:0]        acc_lo;
    logic              acc_err;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;

    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        acc_err  = is_misaligned(req_size, req_addr[1:0]);
        acc_size = req_size;
        acc_lo   = req_addr[1:0];
`else
        // Without trapping, reserved size becomes word and low address bits are dropped to alignment.
        acc_err  = 1'b0;
        acc_size = (req_size == 2'b11) ? SZ_WORD : req_size;
        acc_lo   = req_addr[1:0];
        if (acc_size == SZ_HALF) acc_lo = {req_addr[1], 1'b0};
        if (acc_size == SZ_WORD) acc_lo = 2'b00;
`endif
    end

    lsu_align u_align (
        .size_i      (size_q),
        .lo_i        (lo_q),
        .sgn_i       (sgn_q),
        .rdata_i     (mem_rdata),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            size_q       <= SZ_BYTE;
            lo_q         <= '0;
            sgn_q        <= 1'b0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q  <= 1'b0;
                        size_q       <= acc_size;
                        lo_q         <= acc_lo;
                        sgn_q        <= req_signed;
                        wdata_q      <= req_wdata;
                        resp_rdata_q <= '0;
                        resp_err_q   <= acc_err;
                        if (acc_err) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (!req_wr) begin
                                state_q  <= S_LOAD;
                                mem_rd_q <= 1'b1;
                            end else if (acc_size == SZ_WORD) begin
                                state_q     <= S_WRITE;
                                mem_wr_q    <= 1'b1;
                                mem_wdata_q <= req_wdata;
                            end else begin
                                state_q  <= S_RMW_RD;
                                mem_rd_q <= 1'b1;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    resp_rdata_q <= load_data;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RMW_RD: begin
                    mem_wdata_q <= merged;
                    mem_wr_q    <= 1'b1;
                    state_q     <= S_WRITE;
                end
                S_WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    req_ready_q  <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;

endmodule
